dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port synchronous data memory shared by the RISCV CPU load/store path and a host port.
- The host port is used by the matrix loader and the result readback engine.
- Grants one access per cycle, routes read data back with fixed 1-cycle latency, and bounds host starvation.
- Sits between the CPU core, the host engine and the data memory instance.

Parameters:
ADDR_W, 16, word address width into data memory
DATA_W, 32, data word width
STARVE_MAX, 4, consecutive denied host-request cycles before host gets forced priority (1..15)

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held until cpu_gnt
cpu_we  in  1  CPU write enable (1 = store, 0 = load)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_gnt  out  1  CPU access issued this cycle (combinational)
cpu_rvalid  out  1  CPU load data valid (registered)
cpu_rdata  out  DATA_W  CPU load data
host_req  in  1  host access request; held until host_gnt
host_we  in  1  host write enable
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_lock  in  1  host burst lock; sampled only while host owns the previous grant
host_gnt  out  1  host access issued this cycle (combinational)
host_rvalid  out  1  host read data valid (registered)
host_rdata  out  DATA_W  host read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs are 0, starve_cnt=0, last_owner=CPU, pending read tag cleared. Combinational outputs are 0 while rst=0.
- Reset asserted mid-operation: any in-flight read is dropped; no rvalid follows deassertion.
- Arbitration, evaluated combinationally each cycle; exactly one grant or none:
  - Only one requester active: that requester is granted.
  - Both active: CPU wins by default.
  - Both active: host wins if starve_cnt == STARVE_MAX.
  - Both active: host wins if last_owner=HOST and host_lock=1.
- Issue path: the granted requester's we/addr/wdata drive mem_*, and mem_en=1. With no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their previous values.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on any cycle with host_req=1 and host_gnt=0.
  - Clears on host_gnt=1 or host_req=0.
- last_owner: updated to the granted requester on every grant; unchanged on idle cycles.
- Read return:
  - A granted read (we=0) sets a 1-bit tag register with the owner.
  - Next cycle, the owner's rvalid=1 and its rdata is mem_rdata passed through.
  - The other side's rvalid=0 and its rdata holds its last value.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners return in issue order, one per cycle.
- Throughput: 1 access per cycle; no bubbles between consecutive grants.
- host_lock with host_req=0 has no effect; the lock releases the first cycle host_req or host_lock drops.

Optional Feature:
- DMEM_ARB_STATS_EN defined: adds outputs cpu_grant_cnt[31:0], host_grant_cnt[31:0] and conflict_cnt[31:0].
  - Each counter increments on the respective grant, or on a cycle with both requests high.
  - Reset to 0 and wrap at 2^32.
  - Used by the bench alongside clock_count/instr_cnt for CPI analysis.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- CPU read only: cpu_req=1, cpu_we=0, addr=0x0010, mem returns 0x0000002A -> cpu_gnt same cycle, cpu_rvalid=1 next cycle with cpu_rdata=0x2A, host_rvalid=0.
- Continuous contention, STARVE_MAX=4: both req held 10 cycles, no lock -> grant pattern C,C,C,C,H,C,C,C,C,H.
- Host lock burst: host granted once, then host_lock=1 with cpu_req=1 for 5 writes to 0x1388..0x138C -> 5 consecutive host_gnt, then CPU granted the cycle after host_lock=0.
- Alternating reads: CPU read 0x0005 then host read 0x0006 on consecutive cycles -> cpu_rvalid then host_rvalid on the following two cycles with the matching data.
- Reset mid-read: rst=0 one cycle after a CPU read grant -> all outputs 0, no cpu_rvalid after release, starve_cnt=0.
- With DMEM_ARB_STATS_EN, 10-cycle contention test -> cpu_grant_cnt=8, host_grant_cnt=2, conflict_cnt=10.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// Counter signals exist only when DMEM_ARB_STATS_EN is defined.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_lock;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0]       cpu_grant_cnt;
  logic [31:0]       host_grant_cnt;
  logic [31:0]       conflict_cnt;
`endif

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output cpu_grant_cnt, host_grant_cnt, conflict_cnt
`endif
  );

  // Requester / memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  cpu_grant_cnt, host_grant_cnt, conflict_cnt
`endif
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/host arbiter for the single-port data memory: CPU priority, bounded host starvation,
// host burst lock, 1-cycle read return. Optional grant counters under DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           CLOCK_50,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {OwnCpu, OwnHost} owner_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]        starve_q;
  owner_e            last_q;
  logic              rd_pend_q;
  owner_e            rd_own_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic              host_pri;
  logic              host_gnt;
  logic              cpu_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_rvalid;
  logic              host_rvalid;

  always_comb begin
    host_pri = (starve_q == StarveMax) || ((last_q == OwnHost) && bus.host_lock);
    // Grants are forced low during reset so nothing reaches the memory.
    host_gnt = rst && bus.host_req && (!bus.cpu_req || host_pri);
    cpu_gnt  = rst && bus.cpu_req && !host_gnt;
    mem_en   = cpu_gnt || host_gnt;

    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (host_gnt) begin
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end else if (cpu_gnt) begin
      mem_we    = bus.cpu_we;
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
    end

    cpu_rvalid  = rd_pend_q && (rd_own_q == OwnCpu);
    host_rvalid = rd_pend_q && (rd_own_q == OwnHost);
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.cpu_rvalid  = cpu_rvalid;
  assign bus.host_rvalid = host_rvalid;
  // Read data is the memory output passed straight through; otherwise the last value holds.
  assign bus.cpu_rdata   = cpu_rvalid  ? bus.mem_rdata : cpu_rdata_q;
  assign bus.host_rdata  = host_rvalid ? bus.mem_rdata : host_rdata_q;

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      starve_q     <= '0;
      last_q       <= OwnCpu;
      rd_pend_q    <= 1'b0;
      rd_own_q     <= OwnCpu;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (mem_en) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        last_q  <= host_gnt ? OwnHost : OwnCpu;
      end
      rd_pend_q <= mem_en && !mem_we;
      rd_own_q  <= host_gnt ? OwnHost : OwnCpu;
      if (cpu_rvalid) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (host_rvalid) begin
        host_rdata_q <= bus.mem_rdata;
      end
      if (bus.host_req && !host_gnt) begin
        if (starve_q != StarveMax) begin
          starve_q <= starve_q + 4'd1;
        end
      end else begin
        starve_q <= '0;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cpu_cnt_q;
  logic [31:0] host_cnt_q;
  logic [31:0] conf_cnt_q;

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      cpu_cnt_q  <= '0;
      host_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (cpu_gnt) begin
        cpu_cnt_q <= cpu_cnt_q + 32'd1;
      end
      if (host_gnt) begin
        host_cnt_q <= host_cnt_q + 32'd1;
      end
      if (bus.cpu_req && bus.host_req) begin
        conf_cnt_q <= conf_cnt_q + 32'd1;
      end
    end
  end

  assign bus.cpu_grant_cnt  = cpu_cnt_q;
  assign bus.host_grant_cnt = host_cnt_q;
  assign bus.conflict_cnt   = conf_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a rule-level model, with a small
// behavioural memory on the mem_* side.
module tb_dmem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SMAX = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .CLOCK_50(clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Memory environment: 256 words (address aliased on the low byte), 1-cycle read.
  logic [31:0] tbmem [256];
  initial begin : mem_proc
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) tbmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        else            bus.mem_rdata <= tbmem[bus.mem_addr[7:0]];
      end
    end
  end

  // Model state, updated once per cycle after the compare.
  logic [31:0] mmem [256];
  int          m_starve;
  bit          m_last_host;
  bit          m_pend;
  bit          m_pend_host;
  logic [31:0] m_pend_val;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_crd;
  logic [31:0] m_hrd;
  bit          m_ec;
  bit          m_eh;
  logic [31:0] m_cc;
  logic [31:0] m_hc;
  logic [31:0] m_xc;
  logic [31:0] dtr_c;
  logic [31:0] dtr_h;
  logic [31:0] mtr_h;

  initial begin : cmp_proc
    bit          hpri;
    bit          ec;
    bit          eh;
    bit          e_we;
    logic [31:0] rd;
    dtr_c = '0;
    dtr_h = '0;
    mtr_h = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ctrl", {bus.cpu_gnt, bus.host_gnt, bus.mem_en, bus.mem_we,
                         bus.cpu_rvalid, bus.host_rvalid}, 64'd0);
        chk("rst_addr", bus.mem_addr, 64'd0);
        chk("rst_wdata", bus.mem_wdata, 64'd0);
        chk("rst_rdata", {bus.cpu_rdata, bus.host_rdata}, 64'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("rst_stats", {bus.cpu_grant_cnt, bus.host_grant_cnt}, 64'd0);
        chk("rst_conf", bus.conflict_cnt, 64'd0);
`endif
        m_starve = 0; m_last_host = 0; m_pend = 0; m_pend_host = 0;
        m_addr = '0; m_wdata = '0; m_crd = '0; m_hrd = '0; m_ec = 0; m_eh = 0;
        m_cc = '0; m_hc = '0; m_xc = '0;
      end else begin
        hpri = (m_starve == int'(SMAX)) || (m_last_host && bus.host_lock);
        eh   = bus.host_req && (!bus.cpu_req || hpri);
        ec   = bus.cpu_req && !eh;
        e_we = 1'b0;
        if (eh) begin
          e_we = bus.host_we; m_addr = bus.host_addr; m_wdata = bus.host_wdata;
        end else if (ec) begin
          e_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
        end
        chk("cpu_gnt", bus.cpu_gnt, ec);
        chk("host_gnt", bus.host_gnt, eh);
        chk("mem_en", bus.mem_en, ec || eh);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        if (m_pend && !m_pend_host) m_crd = m_pend_val;
        if (m_pend && m_pend_host)  m_hrd = m_pend_val;
        chk("cpu_rvalid", bus.cpu_rvalid, m_pend && !m_pend_host);
        chk("host_rvalid", bus.host_rvalid, m_pend && m_pend_host);
        chk("cpu_rdata", bus.cpu_rdata, m_crd);
        chk("host_rdata", bus.host_rdata, m_hrd);
`ifdef DMEM_ARB_STATS_EN
        chk("cpu_grant_cnt", bus.cpu_grant_cnt, m_cc);
        chk("host_grant_cnt", bus.host_grant_cnt, m_hc);
        chk("conflict_cnt", bus.conflict_cnt, m_xc);
        m_cc = m_cc + 32'(ec);
        m_hc = m_hc + 32'(eh);
        m_xc = m_xc + 32'(bus.cpu_req && bus.host_req);
`endif
        rd = mmem[m_addr[7:0]];
        m_pend      = (ec || eh) && !e_we;
        m_pend_host = eh;
        m_pend_val  = rd;
        if ((ec || eh) && e_we) mmem[m_addr[7:0]] = m_wdata;
        if (bus.host_req && !eh) m_starve = (m_starve < int'(SMAX)) ? m_starve + 1 : m_starve;
        else                     m_starve = 0;
        if (ec || eh) m_last_host = eh;
        m_ec = ec;
        m_eh = eh;
        dtr_c = {dtr_c[30:0], bus.cpu_gnt};
        dtr_h = {dtr_h[30:0], bus.host_gnt};
        mtr_h = {mtr_h[30:0], eh};
      end
    end
  end

  task automatic step(input bit r, input bit cr, input bit cw, input logic [15:0] ca,
                      input logic [31:0] cd, input bit hr, input bit hw, input logic [15:0] ha,
                      input logic [31:0] hd, input bit hl);
    @(posedge clk);
    #1;
    rst = r;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
    bus.host_lock = hl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 0);
  endtask

  initial begin : stim
    bit          cr, cw, hr, hw, hl;
    logic [15:0] ca, ha;
    logic [31:0] cd, hd;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_lock = 0;
    #1 rst = 1'b0;

    // Requests during reset must not produce grants.
    step(0, 1, 0, 16'h10, 32'h0, 1, 0, 16'h20, 32'h0, 0);
    chk("rst_no_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_no_mem_en", bus.mem_en, 0);
    idle();

    // Continuous contention for 10 cycles.
    for (int i = 0; i < 10; i++)
      step(1, 1, 1, 16'(i), $urandom, 1, 1, 16'(i + 100), $urandom, 0);
    chk("contend_host", dtr_h[9:0], 10'b0000100001);
    chk("contend_cpu", dtr_c[9:0], 10'b1111011110);
    chk("contend_model", mtr_h[9:0], 10'b0000100001);
    idle();
`ifdef DMEM_ARB_STATS_EN
    chk("stat_cpu", bus.cpu_grant_cnt, 8);
    chk("stat_host", bus.host_grant_cnt, 2);
    chk("stat_conf", bus.conflict_cnt, 10);
`endif

    for (int i = 0; i < 256; i++) step(1, 1, 1, 16'(i), init_val(i), 0, 0, 16'h0, 32'h0, 0);

    // Single CPU load.
    step(1, 1, 1, 16'h0010, 32'h0000_002A, 0, 0, 16'h0, 32'h0, 0);
    step(1, 1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0, 0);
    chk("cpu_rd_gnt", bus.cpu_gnt, 1);
    idle();
    chk("cpu_rd_valid", bus.cpu_rvalid, 1);
    chk("cpu_rd_data", bus.cpu_rdata, 32'h0000_002A);
    chk("cpu_rd_host_rv", bus.host_rvalid, 0);

    // Host lock burst against a waiting CPU.
    step(1, 0, 0, 16'h0, 32'h0, 1, 0, 16'h1387, 32'h0, 0);
    for (int k = 0; k < 5; k++)
      step(1, 1, 0, 16'h0040, 32'h0, 1, 1, 16'h1388 + 16'(k), 32'hB000 + 32'(k), 1);
    step(1, 1, 0, 16'h0040, 32'h0, 1, 1, 16'h138D, 32'hB005, 0);
    chk("lock_host", dtr_h[6:0], 7'b1111110);
    chk("lock_cpu", dtr_c[6:0], 7'b0000001);
    step(1, 0, 0, 16'h0, 32'h0, 1, 1, 16'h138D, 32'hB005, 0);
    chk("lock_cpu_rdata", bus.cpu_rdata, init_val(16'h40));
    idle();

    // Alternating reads.
    step(1, 1, 0, 16'h0005, 32'h0, 0, 0, 16'h0, 32'h0, 0);
    step(1, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0006, 32'h0, 0);
    chk("alt_cpu_rv", {bus.cpu_rvalid, bus.host_rvalid}, 2'b10);
    chk("alt_cpu_rd", bus.cpu_rdata, init_val(5));
    idle();
    chk("alt_host_rv", {bus.cpu_rvalid, bus.host_rvalid}, 2'b01);
    chk("alt_host_rd", bus.host_rdata, init_val(6));
    chk("alt_cpu_hold", bus.cpu_rdata, init_val(5));

    // Reset one cycle after a CPU read grant.
    step(1, 1, 0, 16'h0007, 32'h0, 0, 0, 16'h0, 32'h0, 0);
    chk("mid_gnt", bus.cpu_gnt, 1);
    step(0, 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 0);
    chk("mid_rst_rv", bus.cpu_rvalid, 0);
    chk("mid_rst_rd", bus.cpu_rdata, 0);
    idle();
    chk("mid_rel_rv", bus.cpu_rvalid, 0);
    idle();
    chk("mid_rel_rv2", bus.cpu_rvalid, 0);
    for (int i = 0; i < 5; i++)
      step(1, 1, 1, 16'(i), init_val(i), 1, 1, 16'(i + 8), init_val(i + 8), 0);
    chk("mid_starve", dtr_h[4:0], 5'b00001);
    idle();

    // Random traffic; each requester holds its request until granted.
    for (int n = 0; n < 3000; n++) begin
      cr = bus.cpu_req; cw = bus.cpu_we; ca = bus.cpu_addr; cd = bus.cpu_wdata;
      hr = bus.host_req; hw = bus.host_we; ha = bus.host_addr; hd = bus.host_wdata;
      if (!cr || m_ec) begin
        cr = ($urandom_range(0, 3) != 0); cw = 1'($urandom_range(0, 1));
        ca = 16'($urandom_range(0, 15)); cd = $urandom;
      end
      if (!hr || m_eh) begin
        hr = ($urandom_range(0, 2) != 0); hw = 1'($urandom_range(0, 1));
        ha = 16'($urandom_range(0, 15)); hd = $urandom;
      end
      hl = 1'($urandom_range(0, 1));
      step(1, cr, cw, ca, cd, hr, hw, ha, hd, hl);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
